rank_order_spike_sender: RTL and testbench

- Consumes the sorter output (pixel indexes ordered by rank, entry 0 = strongest pixel). Converts it into a rank-order spike train for the SNN core.
- Latches the index list on the sorter's done pulse. Emits one AER event per ranked pixel, in rank order, over a 4-phase REQ/ACK handshake.
- Sits between the sorter and the core's AER input port. Exposes busy so the control logic holds off new_image.

---
 rtl/snn_if_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/rank_order_spike_sender.sv | 116 +++++++++++
 tb/tb_rank_order_spike_sender.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_if_pkg.sv
// Shared SNN front-end types: image geometry, AER width and the spike sender state encoding.
package snn_if_pkg;

    localparam int unsigned IMAGE_SIZE = 5;
    localparam int unsigned INDEX_BITS = $clog2(IMAGE_SIZE);
    localparam int unsigned AER_BITS   = 8;

    typedef logic [INDEX_BITS-1:0] index_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK_LOW,
        REQ_HIGH,
        ACK_HIGH
    } sender_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rank_order_spike_sender.sv
// Turns a rank-sorted pixel index list into a 4-phase REQ/ACK AER spike train, strongest first.
// Define SPIKE_SENDER_ACK_SYNC_EN to pass AER_ACK through a 2-flop synchronizer (cross-clock core).
module rank_order_spike_sender #(
    parameter int unsigned IMAGE_SIZE = snn_if_pkg::IMAGE_SIZE,
    parameter int unsigned INDEX_BITS = $clog2(IMAGE_SIZE),
    parameter int unsigned NUM_SPIKES = IMAGE_SIZE,
    parameter int unsigned AER_BITS   = snn_if_pkg::AER_BITS,
    parameter int unsigned AER_OFFSET = 0
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] sorted_indexes,
    input  logic                                 sorted_valid,
    output logic                                 busy,
    output logic [AER_BITS-1:0]                  AER_ADDR,
    output logic                                 AER_REQ,
    input  logic                                 AER_ACK,
    output logic                                 image_sent
);

    import snn_if_pkg::*;

    localparam int unsigned CNT_BITS = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_SPIKES - 1);

    sender_state_e                        state_q, state_d;
    logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] list_q, list_d;
    logic [CNT_BITS-1:0]                  cnt_q, cnt_d;
    logic                                 busy_d;
    logic                                 req_d;
    logic [AER_BITS-1:0]                  addr_d;
    logic                                 sent_d;
    logic                                 ack_s;

`ifdef SPIKE_SENDER_ACK_SYNC_EN
    sync_2ff u_ack_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (AER_ACK),
        .q     (ack_s)
    );
`else
    assign ack_s = AER_ACK;
`endif

    // Next-state and next-output logic; REQ only rises from WAIT_ACK_LOW, so never while ACK is high.
    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        req_d   = AER_REQ;
        addr_d  = AER_ADDR;
        sent_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sorted_valid) begin
                    list_d  = sorted_indexes;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT_ACK_LOW;
                end
            end
            WAIT_ACK_LOW: begin
                if (!ack_s) begin
                    addr_d  = AER_BITS'(AER_OFFSET + 32'(list_q[cnt_q]));
                    req_d   = 1'b1;
                    state_d = REQ_HIGH;
                end
            end
            REQ_HIGH: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ACK_HIGH;
                end
            end
            ACK_HIGH: begin
                if (!ack_s) begin
                    if (cnt_q == LAST_CNT) begin
                        sent_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_BITS'(1);
                        state_d = WAIT_ACK_LOW;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched list and all outputs are registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            list_q     <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            AER_REQ    <= 1'b0;
            AER_ADDR   <= '0;
            image_sent <= 1'b0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            AER_REQ    <= req_d;
            AER_ADDR   <= addr_d;
            image_sent <= sent_d;
        end
    end

endmodule

// File: tb/tb_rank_order_spike_sender.sv
// Directed bench for rank_order_spike_sender: default instance plus a NUM_SPIKES=2 / AER_OFFSET=16 instance.
module tb_rank_order_spike_sender;

    import snn_if_pkg::*;

    typedef logic [IMAGE_SIZE-1:0][INDEX_BITS-1:0] list_t;

`ifdef SPIKE_SENDER_ACK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Instance 0: default parameters
    logic                sv0    = 1'b0;
    list_t               list0  = '0;
    logic                busy0, req0, sent0, ack0;
    logic [AER_BITS-1:0] addr0;
    logic                resp0  = 1'b0;
    logic                force0 = 1'b0;
    int                  dly_base0 = 0;
    int                  cur_dly0  = 0;
    int                  wcnt0     = 0;
    bit                  rnd0      = 1'b0;

    // Instance 1: two spikes, offset 16
    logic                sv1   = 1'b0;
    list_t               list1 = '0;
    logic                busy1, req1, sent1, ack1;
    logic [AER_BITS-1:0] addr1;
    logic                resp1 = 1'b0;

    assign ack0 = force0 | resp0;
    assign ack1 = resp1;

    rank_order_spike_sender dut0 (
        .CLK(clk), .RST(rst_n), .sorted_indexes(list0), .sorted_valid(sv0), .busy(busy0),
        .AER_ADDR(addr0), .AER_REQ(req0), .AER_ACK(ack0), .image_sent(sent0)
    );

    rank_order_spike_sender #(.NUM_SPIKES(2), .AER_OFFSET(16)) dut1 (
        .CLK(clk), .RST(rst_n), .sorted_indexes(list1), .sorted_valid(sv1), .busy(busy1),
        .AER_ADDR(addr1), .AER_REQ(req1), .AER_ACK(ack1), .image_sent(sent1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Core-side responder: ACK follows REQ after a programmable number of extra cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0 <= 1'b0;
            wcnt0 <= 0;
        end else if (resp0 != req0) begin
            if (wcnt0 >= (rnd0 ? cur_dly0 : dly_base0)) begin
                resp0    <= req0;
                wcnt0    <= 0;
                cur_dly0 <= int'($urandom_range(7, 0));
            end else begin
                wcnt0 <= wcnt0 + 1;
            end
        end else begin
            wcnt0 <= 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) resp1 <= 1'b0;
        else        resp1 <= req1;
    end

    // Event monitors: record addresses on REQ rise, check handshake rules.
    logic                req0_q = 1'b0, req1_q = 1'b0;
    logic [AER_BITS-1:0] addr0_q = '0, addr1_q = '0;
    int                  ev0[$];
    int                  ev1[$];
    int                  sent_cnt0 = 0, sent_cnt1 = 0;

    always @(negedge clk) begin
        if (req0 && !req0_q) begin
            ev0.push_back(int'(addr0));
            chk("req0_rise_with_ack_low", 32'(ack0), 32'd0);
        end
        if (req0 && req0_q) chk("addr0_stable", 32'(addr0), 32'(addr0_q));
        if (sent0) sent_cnt0++;
        req0_q  = req0;
        addr0_q = addr0;
    end

    always @(negedge clk) begin
        if (req1 && !req1_q) begin
            ev1.push_back(int'(addr1));
            chk("req1_rise_with_ack_low", 32'(ack1), 32'd0);
        end
        if (req1 && req1_q) chk("addr1_stable", 32'(addr1), 32'(addr1_q));
        if (sent1) sent_cnt1++;
        req1_q  = req1;
        addr1_q = addr1;
    end

    int expq[$];

    function automatic list_t mk(input int a, input int b, input int c, input int d, input int e);
        list_t l;
        l[0] = INDEX_BITS'(a);
        l[1] = INDEX_BITS'(b);
        l[2] = INDEX_BITS'(c);
        l[3] = INDEX_BITS'(d);
        l[4] = INDEX_BITS'(e);
        return l;
    endfunction

    task automatic pulse0(input list_t l);
        @(negedge clk);
        list0 = l;
        sv0   = 1'b1;
        @(negedge clk);
        sv0   = 1'b0;
    endtask

    task automatic wait_sent0(input string tag, input int budget);
        int n = 0;
        while (!sent0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sent0), 32'd1);
    endtask

    task automatic check_seq0(input string tag);
        chk({tag, "_len"}, 32'(ev0.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i),
                (i < ev0.size()) ? 32'(ev0[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
    endtask

    initial begin
        int n;
        int sc;
        int p[5];
        int j;
        int t;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_sent", 32'(sent0), 32'd0);
        chk("rst_req1", 32'(req1), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1: full image, addresses equal indexes
        expq = '{3, 1, 0, 2, 4};
        list0 = mk(3, 1, 0, 2, 4);
        sv0   = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        chk("s1_busy_capture", 32'(busy0), 32'd1);
        chk("s1_req_not_yet", 32'(req0), 32'd0);
        @(negedge clk);
        chk("s1_req_latency", 32'(req0), 32'd1);
        chk("s1_first_addr", 32'(addr0), 32'd3);
        wait_sent0("s1_done", 300);
        chk("s1_busy_at_sent", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("s1_busy_after", 32'(busy0), 32'd0);
        chk("s1_sent_one_cycle", 32'(sent0), 32'd0);
        check_seq0("s1");
        chk("s1_sent_count", 32'(sent_cnt0), 32'd1);

        // Scenario 2: two spikes with offset 16
        @(negedge clk);
        list1 = mk(4, 0, 1, 2, 3);
        sv1   = 1'b1;
        @(negedge clk);
        sv1 = 1'b0;
        n = 0;
        while (!sent1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("s2_done", 32'(sent1), 32'd1);
        repeat (20) @(negedge clk);
        chk("s2_len", 32'(ev1.size()), 32'd2);
        chk("s2_ev0", (ev1.size() > 0) ? 32'(ev1[0]) : 32'hFFFF_FFFF, 32'd20);
        chk("s2_ev1", (ev1.size() > 1) ? 32'(ev1[1]) : 32'hFFFF_FFFF, 32'd16);
        chk("s2_sent_count", 32'(sent_cnt1), 32'd1);
        chk("s2_busy_idle", 32'(busy1), 32'd0);

        // Scenario 3: sorted_valid while busy is ignored
        dly_base0 = 2;
        ev0.delete();
        expq = '{3, 1, 0, 2, 4};
        pulse0(mk(3, 1, 0, 2, 4));
        n = 0;
        while (ev0.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        pulse0(mk(0, 0, 0, 0, 0));
        chk("s3_busy_during", 32'(busy0), 32'd1);
        wait_sent0("s3_done", 400);
        check_seq0("s3");
        repeat (5) @(negedge clk);
        chk("s3_no_extra_events", 32'(ev0.size()), 32'd5);

        // Scenario 4: ACK held high from reset blocks the first REQ
        dly_base0 = 0;
        force0    = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        ev0.delete();
        expq = '{2, 4, 1, 3, 0};
        pulse0(mk(2, 4, 1, 3, 0));
        repeat (5) @(negedge clk);
        chk("s4_req_held_low", 32'(req0), 32'd0);
        chk("s4_busy", 32'(busy0), 32'd1);
        force0 = 1'b0;
        n = 0;
        while (!req0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s4_req_latency", 32'(n), 32'(1 + SYNC_LAT));
        wait_sent0("s4_done", 400);
        check_seq0("s4");

        // Scenario 5: reset during the third event
        dly_base0 = 3;
        @(negedge clk);
        ev0.delete();
        pulse0(mk(1, 2, 3, 4, 0));
        n = 0;
        while (ev0.size() < 3 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("s5_third_event", 32'(ev0.size()), 32'd3);
        #2;
        chk("s5_req_before_rst", 32'(req0), 32'd1);
        sc = sent_cnt0;
        rst_n = 1'b0;
        #1;
        chk("s5_req_async_low", 32'(req0), 32'd0);
        chk("s5_busy_low", 32'(busy0), 32'd0);
        chk("s5_sent_low", 32'(sent0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s5_no_sent", 32'(sent_cnt0), 32'(sc));
        ev0.delete();
        expq = '{1, 2, 3, 4, 0};
        pulse0(mk(1, 2, 3, 4, 0));
        @(negedge clk);
        chk("s5_restart_addr", 32'(addr0), 32'd1);
        wait_sent0("s5_restart_done", 400);
        check_seq0("s5r");

        // Scenario 6: random permutations with random ACK delays
        rnd0 = 1'b1;
        for (int img = 0; img < 20; img++) begin
            for (int i = 0; i < 5; i++) p[i] = i;
            for (int i = 4; i > 0; i--) begin
                j    = int'($urandom_range(i, 0));
                t    = p[i];
                p[i] = p[j];
                p[j] = t;
            end
            ev0.delete();
            expq.delete();
            for (int i = 0; i < 5; i++) expq.push_back(p[i]);
            pulse0(mk(p[0], p[1], p[2], p[3], p[4]));
            wait_sent0($sformatf("s6_img%0d_done", img), 800);
            check_seq0($sformatf("s6_img%0d", img));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
